main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/arm_mc_pkg.sv | 35 +++
 rtl/aludec.sv | 41 ++++
 rtl/main_fsm.sv | 127 ++++++++++++
 tb/tb_main_fsm.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, ALU controls,
// instruction classes and data-processing commands.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the data-processing cmd/S bits to ALU control, flag-write
// enables and the compare-only NoWrite qualifier.
module aludec
  import arm_mc_pkg::*;
(
  input  logic       ALUOp,
  input  logic [4:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite
);

  logic w_known;

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = '0;
    NoWrite    = 1'b0;
    w_known    = 1'b0;
    if (ALUOp) begin
      w_known = 1'b1;
      case (Funct[4:1])
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          NoWrite    = 1'b1;
        end
        default: w_known = 1'b0;
      endcase
      // Unsupported commands leave every flag enable cleared, even with S set.
      if (w_known) begin
        FlagW[1] = Funct[0];
        FlagW[0] = Funct[0] & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));
      end
    end
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle ARM main controller: Moore state register plus combinational
// per-state datapath controls; reset masks every write/flag enable.
module main_fsm
  import arm_mc_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NoWrite,
  output logic [3:0] state
);

  statetype   r_state;
  logic       w_irwrite, w_nextpc, w_regw, w_memw, w_branch, w_aluop, w_nowrite;
  logic [1:0] w_flagw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:    r_state <= DECODE;
        DECODE: begin
          case (Op)
            OP_MEM:  r_state <= MEMADR;
            OP_DP:   r_state <= Funct[5] ? EXECUTEI : EXECUTER;
            OP_BR:   r_state <= BRANCH;
            default: r_state <= UNKNOWN;
          endcase
        end
        MEMADR:   r_state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:    r_state <= MEMWB;
        EXECUTER: r_state <= ALUWB;
        EXECUTEI: r_state <= ALUWB;
        UNKNOWN:  r_state <= ILLEGAL_TRAP ? UNKNOWN : FETCH;
        default:  r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    w_irwrite = 1'b0;
    w_nextpc  = 1'b0;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_branch  = 1'b0;
    w_aluop   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = '0;
    ResultSrc = '0;
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_nextpc  = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
      end
      EXECUTER: w_aluop = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        w_aluop = 1'b1;
      end
      ALUWB:    w_regw = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  aludec u_aludec (
    .ALUOp      (w_aluop),
    .Funct      (Funct[4:0]),
    .ALUControl (ALUControl),
    .FlagW      (w_flagw),
    .NoWrite    (w_nowrite)
  );

  // Enables are masked by reset directly so a write aborts in the same cycle.
  assign IRWrite = w_irwrite & reset;
  assign NextPC  = w_nextpc & reset;
  assign RegW    = w_regw & reset;
  assign MemW    = w_memw & reset;
  assign FlagW   = w_flagw & {2{reset}};
  assign NoWrite = w_nowrite & reset;
  assign PCS     = (((Rd == 4'hF) & w_regw) | w_branch) & reset;
  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == OP_MEM), (Op == OP_BR)};
  assign state   = r_state;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: state sequences and per-state controls for each
// instruction class, reset abort, and both illegal-op policies.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = '0;
  logic [3:0] Rd = '0;

  logic       IRWrite, AdrSrc, NextPC, ALUSrcA, PCS, RegW, MemW, NoWrite;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW;
  logic [3:0] state;

  logic       n_IRWrite, n_AdrSrc, n_NextPC, n_ALUSrcA, n_PCS, n_RegW, n_MemW, n_NoWrite;
  logic [1:0] n_ALUSrcB, n_ResultSrc, n_ALUControl, n_ImmSrc, n_RegSrc, n_FlagW;
  logic [3:0] n_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  main_fsm #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .NextPC(NextPC), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .state(state)
  );

  main_fsm #(.ILLEGAL_TRAP(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(n_IRWrite), .AdrSrc(n_AdrSrc), .NextPC(n_NextPC), .ALUSrcA(n_ALUSrcA),
    .ALUSrcB(n_ALUSrcB), .ResultSrc(n_ResultSrc), .ALUControl(n_ALUControl),
    .ImmSrc(n_ImmSrc), .RegSrc(n_RegSrc), .FlagW(n_FlagW), .PCS(n_PCS), .RegW(n_RegW),
    .MemW(n_MemW), .NoWrite(n_NoWrite), .state(n_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
      total++; if ({IRWrite, NextPC, RegW, MemW} !== 4'b0000) begin bad++; $display("FAIL rst_enables got=%b exp=0000", {IRWrite, NextPC, RegW, MemW}); end
    end
  endtask

  task automatic test_ldr();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic       exp_rw [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    reset = 1'b1;
    #1;
    total++; if ({IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc} !== 7'b1111010) begin bad++; $display("FAIL fetch_ctl got=%b exp=1111010", {IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc}); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      total++; if (state !== exp_st[i]) begin bad++; $display("FAIL ldr_state[%0d] got=%0d exp=%0d", i, state, exp_st[i]); end
      total++; if (RegW !== exp_rw[i]) begin bad++; $display("FAIL ldr_regw[%0d] got=%b exp=%b", i, RegW, exp_rw[i]); end
      if (i == 2) begin
        total++; if ({ALUSrcB, ImmSrc, RegSrc} !== 6'b010110) begin bad++; $display("FAIL memadr_ctl got=%b exp=010110", {ALUSrcB, ImmSrc, RegSrc}); end
      end
      if (i == 3) begin
        total++; if (AdrSrc !== 1'b1) begin bad++; $display("FAIL memrd_adrsrc got=%b exp=1", AdrSrc); end
      end
      if (i == 4) begin
        total++; if (ResultSrc !== 2'b01) begin bad++; $display("FAIL memwb_res got=%b exp=01", ResultSrc); end
      end
    end
  endtask

  task automatic test_adds();
    Op = 2'b00; Funct = 6'b001001; Rd = 4'd3;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL adds_s0 got=%0d exp=0", state); end
    step();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL adds_s1 got=%0d exp=1", state); end
    total++; if ({ALUControl, FlagW} !== 4'b0000) begin bad++; $display("FAIL decode_alu got=%b exp=0000", {ALUControl, FlagW}); end
    step();
    total++; if (state !== 4'd6) begin bad++; $display("FAIL adds_s6 got=%0d exp=6", state); end
    total++; if ({ALUControl, FlagW, NoWrite} !== 5'b00110) begin bad++; $display("FAIL adds_alu got=%b exp=00110", {ALUControl, FlagW, NoWrite}); end
    step();
    total++; if ({state, RegW, PCS} !== 6'b100010) begin bad++; $display("FAIL adds_aluwb got=%b exp=100010", {state, RegW, PCS}); end
    step();
  endtask

  task automatic test_cmp();
    Op = 2'b00; Funct = 6'b110101; Rd = 4'd0;
    step();
    total++; if (state !== 4'd1) begin bad++; $display("FAIL cmp_s1 got=%0d exp=1", state); end
    step();
    total++; if (state !== 4'd7) begin bad++; $display("FAIL cmp_s7 got=%0d exp=7", state); end
    total++; if ({ALUSrcB, ALUControl, FlagW, NoWrite} !== 7'b0101111) begin bad++; $display("FAIL cmp_alu got=%b exp=0101111", {ALUSrcB, ALUControl, FlagW, NoWrite}); end
    step();
    total++; if (state !== 4'd8) begin bad++; $display("FAIL cmp_s8 got=%0d exp=8", state); end
    step();
  endtask

  task automatic test_unsupported_cmd();
    Op = 2'b00; Funct = 6'b000011; Rd = 4'd1;
    step(); step();
    total++; if ({state, ALUControl, FlagW, NoWrite} !== 9'b0110_00_00_0) begin bad++; $display("FAIL eors_alu got=%b exp=011000000", {state, ALUControl, FlagW, NoWrite}); end
    step(); step();
  endtask

  task automatic test_pcs();
    Op = 2'b00; Funct = 6'b000000; Rd = 4'hF;
    step(); step();
    total++; if ({state, ALUControl, FlagW} !== 8'b0110_10_00) begin bad++; $display("FAIL and_alu got=%b exp=01101000", {state, ALUControl, FlagW}); end
    step();
    total++; if ({state, RegW, PCS} !== 6'b100011) begin bad++; $display("FAIL and_pcs got=%b exp=100011", {state, RegW, PCS}); end
    step();
    Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
    step(); step();
    total++; if ({state, PCS, ALUSrcB, ResultSrc, RegSrc} !== 11'b1001_1_01_10_01) begin bad++; $display("FAIL branch got=%b exp=10011011001", {state, PCS, ALUSrcB, ResultSrc, RegSrc}); end
    step();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL branch_ret got=%0d exp=0", state); end
  endtask

  task automatic test_reset_in_memwr();
    Op = 2'b01; Funct = 6'b011000; Rd = 4'hF;
    step(); step(); step();
    total++; if ({state, MemW, AdrSrc} !== 6'b010111) begin bad++; $display("FAIL memwr got=%b exp=010111", {state, MemW, AdrSrc}); end
    #2 reset = 1'b0;
    #1;
    total++; if ({state, MemW, RegW, PCS} !== 7'b0000000) begin bad++; $display("FAIL memwr_abort got=%b exp=0000000", {state, MemW, RegW, PCS}); end
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_unknown();
    Op = 2'b11; Funct = 6'b000000; Rd = 4'd0;
    step(); step();
    total++; if ({state, n_state} !== 8'hAA) begin bad++; $display("FAIL unk_enter got=%h exp=aa", {state, n_state}); end
    total++; if ({n_IRWrite, n_AdrSrc, n_NextPC, n_ALUSrcA, n_ALUSrcB, n_ResultSrc, n_ALUControl, n_ImmSrc, n_RegSrc, n_FlagW, n_PCS, n_RegW, n_MemW, n_NoWrite} !== 20'b0000_00_00_00_11_00_00_0000) begin
      bad++; $display("FAIL unk_outputs got=%b", {n_IRWrite, n_AdrSrc, n_NextPC, n_ALUSrcA, n_ALUSrcB, n_ResultSrc, n_ALUControl, n_ImmSrc, n_RegSrc, n_FlagW, n_PCS, n_RegW, n_MemW, n_NoWrite});
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      total++; if (state !== 4'd10) begin bad++; $display("FAIL trap_hold[%0d] got=%0d exp=10", k, state); end
      if (k == 1) begin
        total++; if ({n_IRWrite, n_AdrSrc, n_NextPC, n_ALUSrcA, n_ALUSrcB, n_ResultSrc, n_ALUControl, n_ImmSrc, n_RegSrc, n_FlagW, n_PCS, n_RegW, n_MemW, n_NoWrite, n_state} !== 24'b1011_10_10_00_11_00_00_0000_0000) begin
          bad++; $display("FAIL notrap_fetch got=%b", {n_IRWrite, n_AdrSrc, n_NextPC, n_ALUSrcA, n_ALUSrcB, n_ResultSrc, n_ALUControl, n_ImmSrc, n_RegSrc, n_FlagW, n_PCS, n_RegW, n_MemW, n_NoWrite, n_state});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_adds();
    test_cmp();
    test_unsupported_cmd();
    test_pcs();
    test_reset_in_memwr();
    test_unknown();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
